// File: rtl/ofmap_deskew_collector_pkg.sv
// Shared configuration for the ofmap output stage.
// Array geometry, FIFO sizing and the collector FSM state encoding.
package ofmap_deskew_collector_pkg;

  localparam int P_BITWIDTH     = 24;
  localparam int SUPER_SYS_COLS = 4;
  localparam int OFC_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ofc_state_e;

endpackage

// File: rtl/ofmap_deskew_collector_fifo.sv
// First-word fall-through synchronous FIFO, power-of-two depth.
// Reusable by the input-feed path; dout reads zero while empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  assign dout  = empty ? '0 : mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/ofmap_deskew_collector.sv
// Deskews the systolic array's diagonal outputs into whole rows,
// queues them for writeback and tracks per-tile row completion.
module ofmap_deskew_collector
  import ofmap_deskew_collector_pkg::*;
#(
  parameter int COLS  = SUPER_SYS_COLS,
  parameter int PW    = P_BITWIDTH,
  parameter int DEPTH = OFC_FIFO_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   rows_total,
  input  logic               in_valid,
  input  logic [COLS*PW-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COLS*PW-1:0] out_data,
  output logic               stall,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  localparam int W  = COLS * PW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  aligned_data;
  logic          aligned_valid;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          pop, push, push_ok, drop;

  // Column c lags column 0 by c cycles, so it needs COLS-1-c stages.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_thru
      assign aligned_data[c*PW +: PW] = in_data[c*PW +: PW];
    end else begin : g_dly
      logic [PW-1:0] pipe_q [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= in_data[c*PW +: PW];
          for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign aligned_data[c*PW +: PW] = pipe_q[D-1];
    end
  end

  if (COLS == 1) begin : g_v_thru
    assign aligned_valid = in_valid;
  end else begin : g_v_dly
    logic [COLS-2:0] vpipe_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q[0] <= in_valid;
        for (int i = 1; i < COLS - 1; i++) vpipe_q[i] <= vpipe_q[i-1];
      end
    end
    assign aligned_valid = vpipe_q[COLS-2];
  end

  assign pop     = ~fifo_empty & out_ready;
  assign push_ok = ~fifo_full | pop;
  assign push    = aligned_valid & push_ok;
  assign drop    = aligned_valid & ~push_ok;

  sync_fifo_fwft #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (aligned_data),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  // Headroom for the rows already travelling through the deskew pipes.
  assign stall     = (fifo_count >= CW'(DEPTH - COLS));

  ofc_state_e       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             overflow_q, overflow_d;
  logic             zdone_q, zdone_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      overflow_q  <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      overflow_q  <= overflow_d;
      zdone_q     <= zdone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    overflow_d  = overflow_q;
    zdone_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          overflow_d = 1'b0;
          if (rows_total == '0) begin
            zdone_d = 1'b1;
          end else begin
            remaining_d = rows_total;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (pop) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (drop) overflow_d = 1'b1;
  end

  always_comb begin
    busy     = (state_q == RUN);
    done     = (state_q == DONE) | zdone_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_ofmap_deskew_collector.sv
// Directed bench for ofmap_deskew_collector (COLS=4, PW=24, DEPTH=8).
// Cycle-indexed vectors; outputs sampled 1ns after inputs settle.
module tb_ofmap_deskew_collector;

  localparam int COLS  = 4;
  localparam int PW    = 24;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int W     = COLS * PW;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] rows_total;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             stall;
  logic             overflow;
  logic             busy;
  logic             done;

  ofmap_deskew_collector #(
    .COLS  (COLS),
    .PW    (PW),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rows_total (rows_total),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall      (stall),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int k,
                            input logic ev, input logic [W-1:0] ed,
                            input logic es, input logic eo,
                            input logic eb, input logic edn);
    chk($sformatf("%s[%0d] out_valid", tag, k), W'(out_valid), W'(ev));
    if (ev)
      chk($sformatf("%s[%0d] out_data", tag, k), out_data, ed);
    chk($sformatf("%s[%0d] stall", tag, k), W'(stall), W'(es));
    chk($sformatf("%s[%0d] overflow", tag, k), W'(overflow), W'(eo));
    chk($sformatf("%s[%0d] busy", tag, k), W'(busy), W'(eb));
    chk($sformatf("%s[%0d] done", tag, k), W'(done), W'(edn));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Row launch schedule: lrow[n] = row index whose column 0 enters at n.
  int           lrow [64];
  logic [PW-1:0] base;

  task automatic clear_launch();
    for (int i = 0; i < 64; i++) lrow[i] = -1;
  endtask

  function automatic logic [W-1:0] row_word(input int r);
    logic [W-1:0] d;
    d = '0;
    for (int c = 0; c < COLS; c++) d[c*PW +: PW] = PW'(base + r*16 + c);
    return d;
  endfunction

  task automatic drive(input int n);
    logic [W-1:0] d;
    int m;
    d = '0;
    for (int c = 0; c < COLS; c++) begin
      m = n - c;
      if (m >= 0 && m < 64 && lrow[m] >= 0)
        d[c*PW +: PW] = PW'(base + lrow[m]*16 + c);
    end
    in_valid = (n < 64) && (lrow[n] >= 0);
    in_data  = d;
  endtask

  function automatic logic [W-1:0] colv(input int c, input logic [PW-1:0] v);
    logic [W-1:0] d;
    d = '0;
    d[c*PW +: PW] = v;
    return d;
  endfunction

  typedef struct {
    logic             start;
    logic [CNT_W-1:0] rt;
    logic             iv;
    logic [W-1:0]     id;
    logic             ordy;
    logic             ev;
    logic [W-1:0]     ed;
    logic             es;
    logic             eo;
    logic             eb;
    logic             edn;
  } vec_t;

  vec_t tv [10];

  initial begin
    logic [W-1:0] row_a;
    int cnt;
    int head;

    rst = 1'b1; start = 1'b0; rows_total = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0; base = '0;
    clear_launch();

    row_a = {24'h000103, 24'h000102, 24'h000101, 24'h000100};
    tv[0] = '{1'b1, 16'd1, 1'b1, colv(0, 24'h100), 1'b0,
              1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 16'd0, 1'b0, colv(1, 24'h101), 1'b0,
              1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b0, 16'd0, 1'b0, colv(2, 24'h102), 1'b0,
              1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b0, 16'd0, 1'b0, colv(3, 24'h103), 1'b0,
              1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[4] = '{1'b0, 16'd0, 1'b0, '0, 1'b1,
              1'b1, row_a, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[5] = '{1'b0, 16'd0, 1'b0, '0, 1'b0,
              1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[6] = '{1'b0, 16'd0, 1'b0, '0, 1'b0,
              1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7] = '{1'b1, 16'd0, 1'b0, '0, 1'b0,
              1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8] = '{1'b0, 16'd0, 1'b0, '0, 1'b0,
              1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[9] = '{1'b0, 16'd0, 1'b0, '0, 1'b0,
              1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0};

    step();
    step();
    rst = 1'b0;
    #1;
    check_outs("reset", 0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset out_data", out_data, '0);
    step();

    // Single skewed row, then a zero-row tile.
    for (int i = 0; i < 10; i++) begin
      start      = tv[i].start;
      rows_total = tv[i].rt;
      in_valid   = tv[i].iv;
      in_data    = tv[i].id;
      out_ready  = tv[i].ordy;
      #1;
      check_outs("vec", i, tv[i].ev, tv[i].ed, tv[i].es,
                 tv[i].eo, tv[i].eb, tv[i].edn);
      step();
    end

    // Six back-to-back rows with the consumer always ready.
    clear_launch();
    base = '0;
    for (int r = 0; r < 6; r++) lrow[r] = r;
    for (int k = 0; k < 13; k++) begin
      start      = (k == 0);
      rows_total = 16'd6;
      out_ready  = 1'b1;
      drive(k);
      #1;
      check_outs("stream", k, (k >= 4 && k <= 9), row_word(k - 4),
                 1'b0, 1'b0, (k >= 1 && k <= 9), (k == 10));
      step();
    end

    // Fill to full, full push+pop, then a dropped row, then drain.
    clear_launch();
    base = 24'h1000;
    for (int r = 0; r < 10; r++) lrow[r] = r;
    for (int k = 0; k < 23; k++) begin
      start      = (k == 0);
      rows_total = 16'd20;
      out_ready  = (k == 11) || (k >= 14);
      drive(k);
      if (k <= 3)       cnt = 0;
      else if (k <= 11) cnt = k - 3;
      else if (k <= 14) cnt = 8;
      else              cnt = 22 - k;
      if (k <= 11)      head = 0;
      else if (k <= 13) head = 1;
      else              head = k - 13;
      #1;
      check_outs("bp", k, (cnt > 0), row_word(head), (cnt >= 4),
                 (k >= 13), (k >= 1), 1'b0);
      step();
    end
    start = 1'b0;

    // Reset mid-tile: three rows queued, two in flight.
    clear_launch();
    base = 24'h2000;
    for (int r = 0; r < 5; r++) lrow[r] = r;
    for (int k = 0; k < 15; k++) begin
      rst       = (k == 6);
      out_ready = (k >= 7);
      drive(k);
      #1;
      if (k <= 6)
        check_outs("rstmid", k, (k >= 4), row_word(0), 1'b0,
                   1'b1, 1'b1, 1'b0);
      else
        check_outs("rstmid", k, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
